// File: rtl/push_to_axis_fifo.sv
// push_to_axis_fifo: buffers a push-style producer (data + enable, no
// backpressure) into a block RAM and drains it to a valid/ready stream.
// Handshake: a word moves on the stream on every rising edge where
// ovalid && oready; while ovalid=1 and oready=0 odata/ovalid hold, and
// ovalid is a register output so it never depends on oready in the same cycle.
// A three-stage prefetch (read issue, RAM output stage, output register)
// hides the one-cycle RAM read latency so the stream runs at one word per
// cycle. Pushes arriving while count==DEPTH are dropped and latch overflow.
module push_to_axis_fifo #(
    parameter int WIDTH        = 8,
    parameter int SIZE_LOG2    = 10,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     idata,
    input  logic                 ienable,
    output logic                 iafull,
    output logic                 overflow,
    output logic [SIZE_LOG2:0]   count,
    output logic [WIDTH-1:0]     odata,
    output logic                 ovalid,
    input  logic                 oready
);

    localparam int DEPTH = 1 << SIZE_LOG2;
    localparam logic [SIZE_LOG2:0]   DEPTH_C  = (SIZE_LOG2+1)'(DEPTH);
    localparam logic [SIZE_LOG2:0]   MARGIN_C = (SIZE_LOG2+1)'(AFULL_MARGIN);
    localparam logic [SIZE_LOG2:0]   CNT_ONE  = (SIZE_LOG2+1)'(1);
    localparam logic [SIZE_LOG2-1:0] PTR_ONE  = SIZE_LOG2'(1);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [WIDTH-1:0]     ram_q;
    logic                 mid_valid;
    logic [SIZE_LOG2-1:0] wr_ptr;
    logic [SIZE_LOG2-1:0] rd_ptr;
    logic [SIZE_LOG2:0]   ram_unread;
    logic                 push_ok;
    logic                 pop;
    logic                 mid_move;
    logic                 rd_en;

    // A pop in the same cycle never frees a slot for the push.
    assign push_ok  = ienable && (count != DEPTH_C);
    assign pop      = ovalid && oready;
    // The RAM output stage advances when the output register is empty or popped.
    assign mid_move = mid_valid && (!ovalid || oready);
    // Words still sitting in RAM: everything counted minus the two pipeline slots.
    assign ram_unread = count - {{SIZE_LOG2{1'b0}}, mid_valid}
                              - {{SIZE_LOG2{1'b0}}, ovalid};
    // Issue a read when there is an unread word and the RAM output stage
    // will be free at the next edge.
    assign rd_en = (ram_unread != '0) && (!mid_valid || !ovalid || oready);

    // Almost-full from the registered count only.
    assign iafull = (DEPTH_C - count) <= MARGIN_C;

    // Block RAM: synchronous write, registered read, no reset on the array.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= idata;
        end
        if (rd_en) begin
            ram_q <= mem[rd_ptr];
        end
    end

    // Pointers wrap modulo DEPTH by their natural width.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en)   rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Occupancy: +1 on accepted push, -1 on handshake, unchanged on both.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (ienable && !push_ok) begin
            overflow <= 1'b1;
        end
    end

    // RAM output stage valid flag tracks the registered read data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mid_valid <= 1'b0;
        end else begin
            mid_valid <= rd_en || (mid_valid && !mid_move);
        end
    end

    // Output register: load from RAM stage when free, hold while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            odata  <= '0;
            ovalid <= 1'b0;
        end else if (mid_move) begin
            odata  <= ram_q;
            ovalid <= 1'b1;
        end else if (pop) begin
            ovalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_push_to_axis_fifo.sv
// Directed bench for push_to_axis_fifo at WIDTH=8, SIZE_LOG2=10.
// Inputs change and outputs are sampled on the falling edge of clock.
module tb_push_to_axis_fifo;

    localparam int WIDTH     = 8;
    localparam int SIZE_LOG2 = 10;
    localparam int CW        = SIZE_LOG2 + 1;
    localparam int DEPTH     = 1 << SIZE_LOG2;

    logic              clock = 1'b0;
    logic              reset;
    logic [WIDTH-1:0]  idata;
    logic              ienable;
    logic              iafull;
    logic              overflow;
    logic [CW-1:0]     count;
    logic [WIDTH-1:0]  odata;
    logic              ovalid;
    logic              oready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] exp_q [$];

    push_to_axis_fifo #(
        .WIDTH(WIDTH), .SIZE_LOG2(SIZE_LOG2), .AFULL_MARGIN(4)
    ) dut (
        .clock(clock), .reset(reset), .idata(idata), .ienable(ienable),
        .iafull(iafull), .overflow(overflow), .count(count),
        .odata(odata), .ovalid(ovalid), .oready(oready)
    );

    // clock / reset block
    always #5 clock = ~clock;

    task automatic apply_reset;
        reset = 1'b1; ienable = 1'b0; idata = '0; oready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; ienable = 1'b0; idata = '0; oready = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++; if (count !== CW'(0)) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL reset_ovalid: got %b want 0", ovalid); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_checks++; if (odata !== 8'h00) begin n_fail++; $display("FAIL reset_odata: got %h want 00", odata); end
        n_checks++; if (iafull !== 1'b0) begin n_fail++; $display("FAIL reset_iafull: got %b want 0", iafull); end
        reset = 1'b0;
    endtask

    task automatic test_latency;
        ienable = 1'b1; idata = 8'hA5; oready = 1'b1;
        @(negedge clock);
        ienable = 1'b0;
        n_checks++; if (count !== CW'(1)) begin n_fail++; $display("FAIL lat_count_e0: got %0d want 1", count); end
        n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL lat_ovalid_e0: got %b want 0", ovalid); end
        @(negedge clock);
        n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL lat_ovalid_e1: got %b want 0", ovalid); end
        @(negedge clock);
        n_checks++; if (ovalid !== 1'b1) begin n_fail++; $display("FAIL lat_ovalid_e2: got %b want 1", ovalid); end
        n_checks++; if (odata !== 8'hA5) begin n_fail++; $display("FAIL lat_odata_e2: got %h want a5", odata); end
        n_checks++; if (count !== CW'(1)) begin n_fail++; $display("FAIL lat_count_e2: got %0d want 1", count); end
        @(negedge clock);
        n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL lat_ovalid_e3: got %b want 0", ovalid); end
        n_checks++; if (count !== CW'(0)) begin n_fail++; $display("FAIL lat_count_e3: got %0d want 0", count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL lat_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_stream;
        int exp_v;
        logic [7:0] e;
        exp_v = 0;
        oready = 1'b1;
        for (int c = 0; c < 3004; c++) begin
            n_checks++; if (count > CW'(3)) begin n_fail++; $display("FAIL stream_count c=%0d: got %0d want <=3", c, count); end
            if (c >= 3 && c <= 3002) begin
                n_checks++; if (ovalid !== 1'b1) begin n_fail++; $display("FAIL stream_gap c=%0d: got ovalid %b want 1", c, ovalid); end
            end
            if (ovalid === 1'b1) begin
                e = 8'(exp_v);
                n_checks++; if (odata !== e) begin n_fail++; $display("FAIL stream_data n=%0d: got %h want %h", exp_v, odata, e); end
                exp_v++;
            end
            ienable = (c < 3000);
            idata   = 8'(c);
            @(negedge clock);
        end
        ienable = 1'b0;
        n_checks++; if (exp_v != 3000) begin n_fail++; $display("FAIL stream_total: got %0d want 3000", exp_v); end
    endtask

    task automatic test_full;
        logic exp_af;
        logic [7:0] e;
        int got;
        int budget;
        oready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_af = (i >= DEPTH - 4);
            n_checks++; if (count !== CW'(i)) begin n_fail++; $display("FAIL full_count i=%0d: got %0d want %0d", i, count, i); end
            n_checks++; if (iafull !== exp_af) begin n_fail++; $display("FAIL full_iafull i=%0d: got %b want %b", i, iafull, exp_af); end
            ienable = 1'b1;
            idata   = 8'(i) ^ 8'h5A;
            @(negedge clock);
        end
        n_checks++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_count_1024: got %0d want 1024", count); end
        n_checks++; if (iafull !== 1'b1) begin n_fail++; $display("FAIL full_iafull_1024: got %b want 1", iafull); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_overflow_pre: got %b want 0", overflow); end
        ienable = 1'b1; idata = 8'hFF;
        @(negedge clock);
        ienable = 1'b0;
        n_checks++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_count_drop: got %0d want 1024", count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_overflow_set: got %b want 1", overflow); end
        oready = 1'b1;
        got = 0; budget = 0;
        while (got < DEPTH && budget < 2000) begin
            if (ovalid === 1'b1) begin
                e = 8'(got) ^ 8'h5A;
                n_checks++; if (odata !== e) begin n_fail++; $display("FAIL full_drain n=%0d: got %h want %h", got, odata, e); end
                got++;
            end
            budget++;
            @(negedge clock);
        end
        n_checks++; if (got != DEPTH) begin n_fail++; $display("FAIL full_drain_total: got %0d want 1024", got); end
        n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL full_after_drain_ovalid: got %b want 0", ovalid); end
        n_checks++; if (count !== CW'(0)) begin n_fail++; $display("FAIL full_after_drain_count: got %0d want 0", count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_overflow_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_random;
        int model_count;
        int budget;
        logic prev_stall;
        logic [7:0] prev_data;
        logic [7:0] e;
        apply_reset();
        exp_q.delete();
        model_count = 0; prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 600; c++) begin
            n_checks++; if (count !== CW'(model_count)) begin n_fail++; $display("FAIL rand_count c=%0d: got %0d want %0d", c, count, model_count); end
            if (prev_stall) begin
                n_checks++; if (ovalid !== 1'b1 || odata !== prev_data) begin n_fail++; $display("FAIL rand_hold c=%0d: got %b/%h want 1/%h", c, ovalid, odata, prev_data); end
            end
            oready = 1'($urandom_range(0, 1));
            if (ovalid === 1'b1 && oready) begin
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand_extra c=%0d: got %h want none", c, odata); end
                else begin
                    e = exp_q.pop_front();
                    if (odata !== e) begin n_fail++; $display("FAIL rand_data c=%0d: got %h want %h", c, odata, e); end
                    model_count--;
                end
            end
            prev_stall = (ovalid === 1'b1) && !oready;
            prev_data  = odata;
            ienable = 1'b1;
            idata   = 8'($urandom_range(0, 255));
            exp_q.push_back(idata);
            model_count++;
            @(negedge clock);
        end
        ienable = 1'b0; oready = 1'b1; budget = 0;
        while (exp_q.size() != 0 && budget < 3000) begin
            if (ovalid === 1'b1) begin
                e = exp_q.pop_front();
                n_checks++; if (odata !== e) begin n_fail++; $display("FAIL rand_drain: got %h want %h", odata, e); end
            end
            budget++;
            @(negedge clock);
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_lost: got %0d left want 0", exp_q.size()); end
        n_checks++; if (count !== CW'(0) || ovalid !== 1'b0) begin n_fail++; $display("FAIL rand_empty: got count %0d ovalid %b want 0/0", count, ovalid); end
    endtask

    task automatic test_simul_full;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            ienable = 1'b1; idata = 8'(i);
            @(negedge clock);
        end
        n_checks++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL sfull_count_pre: got %0d want 1024", count); end
        n_checks++; if (ovalid !== 1'b1 || odata !== 8'h00) begin n_fail++; $display("FAIL sfull_head: got %b/%h want 1/00", ovalid, odata); end
        ienable = 1'b1; idata = 8'hEE; oready = 1'b1;
        @(negedge clock);
        ienable = 1'b0; oready = 1'b0;
        n_checks++; if (count !== CW'(DEPTH - 1)) begin n_fail++; $display("FAIL sfull_count: got %0d want 1023", count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sfull_overflow: got %b want 1", overflow); end
        n_checks++; if (ovalid !== 1'b1 || odata !== 8'h01) begin n_fail++; $display("FAIL sfull_next: got %b/%h want 1/01", ovalid, odata); end
    endtask

    task automatic test_async_reset;
        ienable = 1'b1; oready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idata = 8'(8'h80 + i);
            @(negedge clock);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL areset_ovalid: got %b want 0", ovalid); end
        n_checks++; if (count !== CW'(0)) begin n_fail++; $display("FAIL areset_count: got %0d want 0", count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL areset_overflow: got %b want 0", overflow); end
        n_checks++; if (iafull !== 1'b0) begin n_fail++; $display("FAIL areset_iafull: got %b want 0", iafull); end
        ienable = 1'b0; oready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        ienable = 1'b1; idata = 8'h3C; oready = 1'b1;
        @(negedge clock);
        ienable = 1'b0;
        n_checks++; if (count !== CW'(1)) begin n_fail++; $display("FAIL areset_post_count: got %0d want 1", count); end
        @(negedge clock);
        n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL areset_post_early: got %b want 0", ovalid); end
        @(negedge clock);
        n_checks++; if (ovalid !== 1'b1 || odata !== 8'h3C) begin n_fail++; $display("FAIL areset_first_word: got %b/%h want 1/3c", ovalid, odata); end
        @(negedge clock);
        n_checks++; if (ovalid !== 1'b0 || count !== CW'(0)) begin n_fail++; $display("FAIL areset_drained: got %b/%0d want 0/0", ovalid, count); end
    endtask

    task automatic test_simul_5;
        oready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ienable = 1'b1; idata = 8'(8'h10 + i);
            @(negedge clock);
        end
        n_checks++; if (count !== CW'(5)) begin n_fail++; $display("FAIL s5_count_pre: got %0d want 5", count); end
        n_checks++; if (ovalid !== 1'b1 || odata !== 8'h10) begin n_fail++; $display("FAIL s5_head: got %b/%h want 1/10", ovalid, odata); end
        ienable = 1'b1; idata = 8'h15; oready = 1'b1;
        @(negedge clock);
        ienable = 1'b0; oready = 1'b0;
        n_checks++; if (count !== CW'(5)) begin n_fail++; $display("FAIL s5_count: got %0d want 5", count); end
        n_checks++; if (ovalid !== 1'b1 || odata !== 8'h11) begin n_fail++; $display("FAIL s5_next: got %b/%h want 1/11", ovalid, odata); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL s5_overflow: got %b want 0", overflow); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stream();
        test_full();
        test_random();
        test_simul_full();
        test_async_reset();
        test_simul_5();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/push_to_axis_fifo.md
Name: push_to_axis_fifo

Overview:
- Parametrised successor to the simple push-to-stream bridge.
- Buffers a push-style producer (data plus enable, no backpressure) into block RAM.
- Drains the RAM to an AXI-stream style valid/ready consumer at full throughput.
- Adds occupancy tracking, a programmable almost-full threshold, drop-on-full with a sticky overflow flag, and a prefetch stage that hides the one-cycle RAM read latency.

Parameters:
- WIDTH, 8, data word width in bits.
- SIZE_LOG2, 10, log2 of RAM depth; DEPTH = 2^SIZE_LOG2 words.
- AFULL_MARGIN, 4, iafull asserts when free slots <= AFULL_MARGIN; legal range 0..DEPTH-1.

Ports:
- clock  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-high reset.
- idata  input  WIDTH  push data.
- ienable  input  1  push strobe; idata is sampled on the rising edge when high.
- iafull  output  1  almost-full indication to the producer.
- overflow  output  1  sticky flag: a push was dropped.
- count  output  SIZE_LOG2+1  words held: RAM plus prefetch plus output register.
- odata  output  WIDTH  stream data.
- ovalid  output  1  stream valid.
- oready  input  1  stream ready.

Behaviour:
- One clock, named clock. Reset is asynchronous and active-high, named reset.
- Reset values:
  - count=0, overflow=0, ovalid=0, odata=0.
  - iafull=0 when AFULL_MARGIN<DEPTH.
  - Internal write/read pointers=0, prefetch valid flags=0.
- Reset asserted mid-operation discards all contents immediately, with no wait for a clock edge.
- Push acceptance:
  - A push is accepted iff ienable=1 and count<DEPTH at the sampling edge.
  - A pop in the same cycle does not free a slot for that push.
- Drop on full: ienable=1 with count==DEPTH discards the word. Pointers and count are unchanged. overflow is set to 1 on that edge and stays 1 until reset.
- Count and pointer arithmetic:
  - count += accepted push; count -= (ovalid && oready).
  - Simultaneous push and pop leaves count unchanged.
  - count never exceeds DEPTH and never underflows.
  - Pointers are SIZE_LOG2 bits and wrap modulo DEPTH naturally.
- iafull = (DEPTH - count) <= AFULL_MARGIN, decoded combinationally from the count register.
- RAM: simple dual-port, registered read, one cycle of read latency, inferred as block RAM.
- Prefetch pipeline:
  - Three stages: RAM read issue, RAM output stage, and the output register (odata/ovalid).
  - A read is issued whenever the RAM holds unread words and the downstream stages will have room at the next edge. Room means the output register is empty or being popped, or the RAM output stage is free.
- Output holding (AXI-stream rules):
  - While ovalid=1 and oready=0, odata and ovalid hold stable.
  - ovalid never drops without a handshake.
  - ovalid does not depend combinationally on oready.
- Latency: on an empty FIFO, a push sampled at edge k gives ovalid=1 and odata=that word after edge k+2.
- Throughput: with oready held high and continuous pushes, one word per cycle leaves after the initial latency.
- Order is strict FIFO across pointer wrap-around.
- Full: count==DEPTH with the output register occupied. The RAM is never overwritten before its word is read, because RAM occupancy <= count <= DEPTH.
- Empty: count==0 implies ovalid=0. Pops are impossible, so count cannot underflow.
- oready is a don't-care while ovalid=0.

Test Plan:
- Reset then a single push of 0xA5 at edge 0, oready=1 -> ovalid rises after edge 2 with odata=0xA5. count goes 1 then 0 after the handshake edge. overflow=0.
- Stream 3000 incrementing bytes with ienable=1 and oready=1 every cycle (SIZE_LOG2=10) -> output sequence 0..2999 mod 256 in order, one per cycle after latency. Pointers wrap twice. count stays <=3.
- oready=0, push 1024 words -> count=1024. iafull first asserts when count reaches 1020. A 1025th push is dropped and overflow=1. Then oready=1 drains exactly the first 1024 values in order, and overflow remains 1.
- Random oready (50%) with continuous pushes below capacity -> no lost or duplicated words. odata stable whenever ovalid=1 and oready=0. count equals pushes minus pops at every edge.
- Simultaneous push and pop at count==DEPTH -> push dropped and overflow set, count becomes DEPTH-1. Simultaneous push and pop at count==5 -> count stays 5.
- Assert reset asynchronously mid-stream between edges -> ovalid, count and overflow go 0 immediately. After release, the next push 0x3C is the first word out.
